// File: rtl/vga_text_buf_pkg.sv
// Shared geometry helpers, control codes and FSM encoding
// for the VGA text buffer.
package vga_text_pkg;

   function automatic int cols_of(input int h);
      return h / 8;
   endfunction

   function automatic int rows_of(input int v);
      return v / 8;
   endfunction

   function automatic int cells_of(input int h, input int v);
      return cols_of(h) * rows_of(v);
   endfunction

   function automatic int caw_of(input int h, input int v);
      return $clog2(cells_of(h, v));
   endfunction

   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_SPACE = 8'h20;
   localparam logic [7:0] CH_PR_HI = 8'h7E;

   typedef enum logic [1:0] {
      ST_CLEAR      = 2'd0,
      ST_IDLE       = 2'd1,
      ST_SCROLL_CLR = 2'd2
   } state_e;

endpackage

// File: rtl/vga_text_buf_if.sv
// Character stream handshake into the text buffer.
// master drives bytes, slave accepts them.
interface vga_text_buf_if;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_char;

   modport master (output in_valid, output in_char, input in_ready);
   modport slave  (input in_valid, input in_char, output in_ready);
endinterface

// File: rtl/vga_text_buf_ram.sv
// Simple dual-port byte RAM, read-first, registered read.
// Written plainly so synthesis maps it onto block RAM.
module text_ram #(
   parameter int AW    = 15,
   parameter int DEPTH = 20480
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_text_buf.sv
// Scrolling text-mode character buffer: byte stream in,
// cell reads out with a ring-buffer row offset.
module vga_text_buf
   import vga_text_pkg::*;
#(
   parameter int h_disp = 1280,
   parameter int v_disp = 1024,
   localparam int COLS  = cols_of(h_disp),
   localparam int ROWS  = rows_of(v_disp),
   localparam int CELLS = cells_of(h_disp, v_disp),
   localparam int CAW   = caw_of(h_disp, v_disp),
   localparam int XW    = $clog2(COLS),
   localparam int YW    = $clog2(ROWS)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [7:0]     in_char,
   input  logic [CAW-1:0] addr_read,
   output logic [7:0]     char_read,
   output logic [XW-1:0]  cursor_x,
   output logic [YW-1:0]  cursor_y
);

   localparam logic [CAW:0]   CELLS_W  = (CAW+1)'(CELLS);
   localparam logic [CAW-1:0] COLS_A   = CAW'(COLS);
   localparam logic [CAW-1:0] LROW_A   = CAW'((ROWS-1)*COLS);
   localparam logic [CAW-1:0] CLR_LAST = CAW'(CELLS-1);
   localparam logic [CAW-1:0] SCR_LAST = CAW'(COLS-1);
   localparam logic [XW-1:0]  X_LAST   = XW'(COLS-1);
   localparam logic [YW-1:0]  Y_LAST   = YW'(ROWS-1);

   // logical -> physical cell, modulo CELLS (a, b both < CELLS)
   function automatic logic [CAW-1:0] wrap_add(
      input logic [CAW-1:0] a,
      input logic [CAW-1:0] b
   );
      logic [CAW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= CELLS_W) s = s - CELLS_W;
      return s[CAW-1:0];
   endfunction

   state_e         state_q, state_d;
   logic [CAW-1:0] cnt_q, cnt_d;
   logic [XW-1:0]  x_q, x_d;
   logic [YW-1:0]  y_q, y_d;
   logic [CAW-1:0] top_q, top_d;
   logic           zero_q;
   logic           newline;
   logic           is_prn, is_lf, is_cr, is_bs, is_ff;
   logic [CAW-1:0] cur_cell;
   logic           we;
   logic [CAW-1:0] waddr;
   logic [7:0]     wdata;
   logic [CAW-1:0] raddr;
   logic [7:0]     rdata;
   logic           oob;

   assign is_prn = (in_char >= CH_SPACE) && (in_char <= CH_PR_HI);
   assign is_lf  = (in_char == CH_LF);
   assign is_cr  = (in_char == CH_CR);
   assign is_bs  = (in_char == CH_BS);
   assign is_ff  = (in_char == CH_FF);

   assign cur_cell = CAW'(y_q) * COLS_A + CAW'(x_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         top_q   <= '0;
         zero_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         x_q     <= x_d;
         y_q     <= y_d;
         top_q   <= top_d;
         zero_q  <= oob;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      x_d     = x_q;
      y_d     = y_q;
      top_d   = top_q;
      newline = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CLR_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_SCROLL_CLR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SCR_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_IDLE: begin
            if (in_valid) begin
               unique case (1'b1)
                  is_prn: begin
                     if (x_q == X_LAST) begin
                        x_d     = '0;
                        newline = 1'b1;
                     end else begin
                        x_d = x_q + 1'b1;
                     end
                  end
                  is_lf: begin
                     x_d     = '0;
                     newline = 1'b1;
                  end
                  is_cr: x_d = '0;
                  is_bs: if (x_q != '0) x_d = x_q - 1'b1;
                  is_ff: begin
                     x_d     = '0;
                     y_d     = '0;
                     top_d   = '0;
                     cnt_d   = '0;
                     state_d = ST_CLEAR;
                  end
                  default: ;
               endcase
               // bottom row: scroll by advancing the ring offset
               if (newline) begin
                  if (y_q == Y_LAST) begin
                     top_d   = wrap_add(top_q, COLS_A);
                     cnt_d   = '0;
                     state_d = ST_SCROLL_CLR;
                  end else begin
                     y_d = y_q + 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      in_ready = (state_q == ST_IDLE);
      we       = 1'b0;
      waddr    = '0;
      wdata    = CH_SPACE;
      unique case (state_q)
         ST_CLEAR: begin
            we    = 1'b1;
            waddr = cnt_q;
         end
         ST_SCROLL_CLR: begin
            we    = 1'b1;
            waddr = wrap_add(LROW_A + cnt_q, top_q);
         end
         ST_IDLE: begin
            if (in_valid && is_prn) begin
               we    = 1'b1;
               waddr = wrap_add(cur_cell, top_q);
               wdata = in_char;
            end else if (in_valid && is_bs && x_q != '0) begin
               we    = 1'b1;
               waddr = wrap_add(cur_cell - 1'b1, top_q);
            end
         end
         default: ;
      endcase
      if (reset) we = 1'b0;
   end

   assign oob   = ({1'b0, addr_read} >= CELLS_W);
   assign raddr = wrap_add(addr_read, top_q);

   text_ram #(
      .AW    (CAW),
      .DEPTH (CELLS)
   ) u_ram (
      .clk     (clk),
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   assign char_read = zero_q ? 8'h00 : rdata;
   assign cursor_x  = x_q;
   assign cursor_y  = y_q;

endmodule

// File: tb/tb_vga_text_buf.sv
// Directed bench for vga_text_buf at the default
// 160x128 character geometry.
module tb_vga_text_buf;

   localparam int CELLS = 20480;
   localparam int LIMIT = 30000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [14:0] addr_read = '0;
   logic [7:0]  char_read;
   logic [7:0]  cursor_x;
   logic [6:0]  cursor_y;
   int          checks = 0;
   int          errors = 0;
   int          n;
   int          bad;

   vga_text_buf_if sif ();

   vga_text_buf #(
      .h_disp (1280),
      .v_disp (1024)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (sif.in_valid),
      .in_ready  (sif.in_ready),
      .in_char   (sif.in_char),
      .addr_read (addr_read),
      .char_read (char_read),
      .cursor_x  (cursor_x),
      .cursor_y  (cursor_y)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready(output int cnt);
      cnt = 0;
      while (sif.in_ready !== 1'b1 && cnt < LIMIT) begin
         cnt++;
         @(negedge clk);
      end
   endtask

   task automatic send(input logic [7:0] ch);
      int w;
      wait_ready(w);
      if (w >= LIMIT) chk("send_timeout", w, 0);
      sif.in_valid = 1'b1;
      sif.in_char  = ch;
      @(negedge clk);
      sif.in_valid = 1'b0;
   endtask

   task automatic rd(input logic [14:0] a, input logic [7:0] exp,
                     input string tag);
      addr_read = a;
      @(negedge clk);
      chk(tag, char_read, exp);
   endtask

   task automatic cur(input logic [7:0] x, input logic [6:0] y,
                      input string tag);
      chk({tag, "_x"}, cursor_x, x);
      chk({tag, "_y"}, cursor_y, y);
   endtask

   initial begin
      sif.in_valid = 1'b0;
      sif.in_char  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ready", sif.in_ready, 0);
      chk("rst_char", char_read, 0);
      cur(0, 0, "rst_cur");

      reset = 1'b0;
      wait_ready(n);
      chk("clear_len", n, 20480);
      chk("ready_after_clear", sif.in_ready, 1);
      rd(0, 8'h20, "clear_cell0");
      rd(15'd20479, 8'h20, "clear_last");

      send(8'h41);
      send(8'h42);
      rd(0, 8'h41, "wr_a");
      rd(1, 8'h42, "wr_b");
      cur(2, 0, "ab_cur");

      addr_read    = 15'd2;
      sif.in_valid = 1'b1;
      sif.in_char  = 8'h43;
      @(negedge clk);
      sif.in_valid = 1'b0;
      chk("read_first", char_read, 8'h20);
      rd(2, 8'h43, "after_rf");
      cur(3, 0, "rf_cur");

      send(8'h0D);
      cur(0, 0, "cr_cur");
      send(8'h41);
      send(8'h08);
      rd(0, 8'h20, "bs_space");
      cur(0, 0, "bs_cur");
      send(8'h08);
      cur(0, 0, "bs0_cur");
      rd(1, 8'h42, "bs0_keep");

      for (int i = 0; i < 160; i++) send(8'h78);
      cur(0, 1, "wrap_cur");
      rd(0, 8'h78, "row0_first");
      rd(159, 8'h78, "row0_last");
      send(8'h79);
      rd(160, 8'h79, "row1_first");
      cur(1, 1, "row1_cur");

      send(8'h0D);
      cur(0, 1, "cr2_cur");
      send(8'h01);
      cur(0, 1, "ign_cur");
      chk("ign_ready", sif.in_ready, 1);
      send(8'h0A);
      cur(0, 2, "lf_cur");
      rd(15'd20480, 8'h00, "oob_20480");
      rd(15'd32767, 8'h00, "oob_max");

      send(8'h0C);
      cur(0, 0, "ff_cur");
      chk("ff_busy", sif.in_ready, 0);
      wait_ready(n);
      chk("ff_clear_len", n, 20480);
      rd(160, 8'h20, "ff_cleared");

      send(8'h0A);
      send(8'h51);
      for (int i = 0; i < 126; i++) send(8'h0A);
      cur(0, 127, "bottom_cur");
      send(8'h0A);
      wait_ready(n);
      chk("scroll_len", n, 160);
      cur(0, 127, "scroll_cur");
      rd(0, 8'h51, "scroll_top");
      bad = 0;
      for (int a = 20320; a < CELLS; a++) begin
         addr_read = 15'(a);
         @(negedge clk);
         if (char_read !== 8'h20) bad++;
      end
      chk("scroll_row_blank", bad, 0);
      send(8'h5A);
      rd(15'd20320, 8'h5A, "scroll_wr");
      cur(1, 127, "scroll_wr_cur");

      send(8'h0A);
      repeat (40) @(negedge clk);
      chk("mid_scroll_busy", sif.in_ready, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      cur(0, 0, "rst2_cur");
      chk("rst2_ready", sif.in_ready, 0);
      chk("rst2_char", char_read, 0);
      reset = 1'b0;
      wait_ready(n);
      chk("rst2_clear_len", n, 20480);

      bad = 0;
      addr_read = '0;
      @(negedge clk);
      for (int a = 1; a <= CELLS; a++) begin
         if (char_read !== 8'h20) bad++;
         addr_read = 15'(a);
         @(negedge clk);
      end
      chk("all_blank", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_text_buf.md
VGA_TEXT_BUF -- requirements
Module: vga_text_buf

Interface
REQ-001 SHALL have parameter h_disp, default 1280, visible pixel width; COLS = h_disp/8.
REQ-002 SHALL have parameter v_disp, default 1024, visible pixel height; ROWS = v_disp/8.
REQ-003 SHALL derive CELLS = COLS*ROWS (20480 by default) and CAW = $clog2(CELLS) (15 by default).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1, a character byte is offered.
REQ-007 SHALL have port in_ready, output, 1, a byte is accepted when in_valid && in_ready.
REQ-008 SHALL have port in_char, input, 8, the offered byte (ASCII or control code).
REQ-009 SHALL have port addr_read, input, CAW, the logical cell address (row*COLS+col) requested by the display controller.
REQ-010 SHALL have port char_read, output, 8, the cell contents for addr_read.
REQ-011 SHALL have port cursor_x, output, $clog2(COLS), the current write column.
REQ-012 SHALL have port cursor_y, output, $clog2(ROWS), the current write row.

Function
REQ-013 SHALL store CELLS bytes in a RAM with one write port and one registered read port.
REQ-014 SHALL translate reads as phys = addr_read + top_off, minus CELLS when the sum is >= CELLS; top_off is a multiple of COLS.
REQ-015 SHALL present char_read = mem[phys] exactly 1 cycle after addr_read is sampled; if addr_read >= CELLS, char_read SHALL be 0x00.
REQ-016 SHALL be read-first: on a same-cycle write and read to the same cell, char_read SHALL return the old byte.
REQ-017 SHALL serve reads in every state, including while clearing; partially cleared rows may be displayed.
REQ-018 SHALL use three FSM states: CLEAR, IDLE and SCROLL_CLR; in_ready SHALL be 1 only in IDLE.
REQ-019 CLEAR SHALL write 0x20 to one physical cell per cycle, from 0 to CELLS-1 (CELLS cycles), then go to IDLE.
REQ-020 In IDLE, a byte in 0x20..0x7E SHALL be written at cell cursor_y*COLS+cursor_x (translated per REQ-014), then cursor_x SHALL increment; at cursor_x==COLS-1 it SHALL instead set cursor_x=0 and perform a newline.
REQ-021 0x0A (LF) SHALL set cursor_x=0 and perform a newline.
REQ-022 0x0D (CR) SHALL set cursor_x=0 only.
REQ-023 0x08 (BS) with cursor_x>0 SHALL decrement cursor_x and write 0x20 at the new position; with cursor_x==0 it SHALL do nothing.
REQ-024 0x0C (FF) SHALL set top_off=0 and cursor=(0,0), then enter CLEAR.
REQ-025 Any other byte SHALL be accepted and ignored.
REQ-026 A newline with cursor_y<ROWS-1 SHALL increment cursor_y.
REQ-027 A newline with cursor_y==ROWS-1 SHALL: keep cursor_y; set top_off += COLS, wrapping to 0 at CELLS; enter SCROLL_CLR.
REQ-028 SCROLL_CLR SHALL write 0x20 to the COLS cells of logical row ROWS-1 under the new top_off, one per cycle (exactly COLS cycles with in_ready=0), then return to IDLE.
REQ-029 A new top_off SHALL affect read translation from the cycle after it is updated.

Reset
REQ-030 While reset is high: state=CLEAR with clear counter 0, in_ready=0, cursor_x=0, cursor_y=0, top_off=0, char_read=0x00.
REQ-031 Reset asserted in any state, including mid-CLEAR or mid-SCROLL_CLR, SHALL restart the full clear; the first clear write SHALL occur in the first cycle after reset deasserts.

Structure
REQ-032 Package vga_text_pkg SHALL hold the COLS/ROWS/CELLS/CAW derivations, the control-code constants (LF, CR, BS, FF, SPACE) and the FSM state encoding.
REQ-033 RAM SHALL be sub-module text_ram: simple dual-port, read-first, registered read, inferable as block RAM.

Verification
REQ-034 Release reset -> in_ready=0 for 20480 cycles and 1 on the next cycle; addr_read=0 -> char_read=0x20 one cycle later.
REQ-035 Send 0x41, 0x42 -> addr 0 reads 0x41, addr 1 reads 0x42, cursor=(2,0).
REQ-036 Send 160x 0x78 -> cursor=(0,1); a 161st 0x79 is read back at addr 160.
REQ-037 Send 0x41 then 0x08 -> addr 0 reads 0x20, cursor_x=0; a second 0x08 leaves cursor=(0,0).
REQ-038 Write 0x51 at row 1 col 0, move to row 127, send 0x0A -> in_ready=0 for exactly 160 cycles; then addr 0 reads 0x51 and addr 20320..20479 read 0x20.
REQ-039 Assert reset during SCROLL_CLR -> cursor=(0,0), top_off=0, 20480-cycle clear, then all cells read 0x20.
